// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time to instruction memory and
// buffers returned words with their PCs in a small FIFO toward decode; redirects flush everything.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [63:0] inst_pc
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [63:0]        req_pc_q, req_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        data_q [FIFO_DEPTH];
    logic [63:0]        pcs_q  [FIFO_DEPTH];
    logic [31:0]        last_instr_q;
    logic [63:0]        last_pc_q;
    logic               push_s;
    logic               pop_s;
    logic               req_valid_s;
    logic [63:0]        redirect_pc_s;

    assign redirect_pc_s  = redirect_pc & ~64'h3;
    assign imem_req_addr  = pc_q;
    assign imem_req_valid = req_valid_s;
    assign inst_valid     = (count_q != {CNT_W{1'b0}});
    assign pop_s          = inst_valid & inst_ready;

    // Head entry while non-empty; otherwise the last head shown stays on the outputs.
    always_comb begin
        instruction = last_instr_q;
        inst_pc     = last_pc_q;
        if (inst_valid) begin
            instruction = data_q[rd_ptr_q];
            inst_pc     = pcs_q[rd_ptr_q];
        end else begin
            instruction = last_instr_q;
            inst_pc     = last_pc_q;
        end
    end

    // Fetch sequencer: next state, next PC, request valid and response push.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        push_s      = 1'b0;
        req_valid_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) begin
                    pc_d = redirect_pc_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_REQ: begin
                req_valid_s = (count_q < DEPTH_C) & ~redirect_valid;
                if (redirect_valid) begin
                    pc_d = redirect_pc_s;
                end else if (req_valid_s && imem_req_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 64'd4;
                    state_d  = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                    if (redirect_valid) begin
                        pc_d = redirect_pc_s;
                    end else begin
                        push_s = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc_s;
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc_s;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state, PC and address of the fetch in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= 64'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Instruction buffer; a redirect flush takes priority over push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q     <= {PTR_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            last_instr_q <= 32'h0;
            last_pc_q    <= 64'h0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_q[i] <= 32'h0;
                pcs_q[i]  <= 64'h0;
            end
        end else begin
            if (inst_valid) begin
                last_instr_q <= data_q[rd_ptr_q];
                last_pc_q    <= pcs_q[rd_ptr_q];
            end else begin
                last_instr_q <= last_instr_q;
                last_pc_q    <= last_pc_q;
            end
            if (redirect_valid) begin
                rd_ptr_q <= {PTR_W{1'b0}};
                wr_ptr_q <= {PTR_W{1'b0}};
                count_q  <= {CNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    data_q[wr_ptr_q] <= imem_rsp_data;
                    pcs_q[wr_ptr_q]  <= req_pc_q;
                    wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                end else begin
                    wr_ptr_q <= wr_ptr_q;
                end
                if (pop_s) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end else begin
                    rd_ptr_q <= rd_ptr_q;
                end
                case ({push_s, pop_s})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: randomized memory latency, backpressure and
// redirects checked against a sequential-PC reference model, plus directed boundary scenarios.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [63:0] inst_pc;

    instruction_fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    // Reference model: next PC decode must see, next address memory must see.
    logic [63:0] exp_pop_pc;
    logic [63:0] exp_req_pc;
    // Memory model: one pending response with a countdown.
    logic        mem_pend;
    int          mem_dly;
    logic [63:0] mem_addr;
    int          lat_min, lat_max, req_pct, rdy_pct;
    int          accepts, pops;
    logic [63:0] last_acc;
    logic        sv_inst_valid, sv_req_valid;
    logic [31:0] sv_instr;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
    endfunction

    function automatic logic chance(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic model_clear();
        exp_pop_pc = 64'h0;
        exp_req_pc = 64'h0;
        mem_pend   = 1'b0;
        mem_dly    = 0;
        accepts    = 0;
        pops       = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0; inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    // One cycle: drive at the falling edge, sample 1ns later, check handshakes against the model.
    task automatic step(input logic rv, input logic [63:0] rpc);
        @(negedge clk);
        if (mem_pend && mem_dly == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
            mem_pend       = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (mem_pend) mem_dly = mem_dly - 1;
        end
        imem_req_ready = chance(req_pct);
        inst_ready     = chance(rdy_pct);
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        sv_inst_valid = inst_valid;
        sv_req_valid  = imem_req_valid;
        sv_instr      = instruction;
        if (rv) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_during_redirect: imem_req_valid=%b expected 0", imem_req_valid);
            end
        end
        if (inst_valid && inst_ready) begin
            checks++;
            if (inst_pc !== exp_pop_pc) begin
                errors++;
                $display("FAIL inst_pc: got %h expected %h", inst_pc, exp_pop_pc);
            end
            checks++;
            if (instruction !== mem_word(exp_pop_pc)) begin
                errors++;
                $display("FAIL instruction: got %h expected %h", instruction, mem_word(exp_pop_pc));
            end
            exp_pop_pc = exp_pop_pc + 64'd4;
            pops++;
        end
        if (imem_req_valid && imem_req_ready) begin
            checks++;
            if (imem_req_addr !== exp_req_pc) begin
                errors++;
                $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_req_pc);
            end
            last_acc   = imem_req_addr;
            exp_req_pc = imem_req_addr + 64'd4;
            accepts++;
            mem_pend = 1'b1;
            mem_addr = imem_req_addr;
            mem_dly  = $urandom_range(lat_max - lat_min) + lat_min - 1;
        end
        if (rv) begin
            exp_req_pc = {rpc[63:2], 2'b00};
            exp_pop_pc = {rpc[63:2], 2'b00};
        end
    endtask

    task automatic wait_accept(input int n0, input string name);
        int guard = 0;
        while (accepts == n0 && guard < 40) begin
            step(1'b0, 64'h0);
            guard++;
        end
        if (accepts == n0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no request accepted in %0d cycles", name, guard);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0; inst_ready = 1'b1;
        #1;
        checks += 5;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
        if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL rst_req_addr: got %h expected 0", imem_req_addr); end
        if (instruction !== 32'h0) begin errors++; $display("FAIL rst_instruction: got %h expected 0", instruction); end
        if (inst_pc !== 64'h0) begin errors++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
    endtask

    task automatic test_sequential();
        lat_min = 1; lat_max = 1; req_pct = 100; rdy_pct = 100;
        do_reset();
        repeat (20) step(1'b0, 64'h0);
        checks++;
        if (pops < 8) begin errors++; $display("FAIL seq_throughput: got %0d pops expected >= 8", pops); end
    endtask

    task automatic test_backpressure();
        lat_min = 1; lat_max = 1; req_pct = 100; rdy_pct = 0;
        do_reset();
        repeat (20) step(1'b0, 64'h0);
        checks++;
        if (accepts !== 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", accepts); end
        checks++;
        if (sv_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", sv_req_valid); end
        rdy_pct = 100;
        wait_accept(2, "bp_resume");
        checks++;
        if (last_acc !== 64'h8) begin errors++; $display("FAIL bp_resume_addr: got %h expected 8", last_acc); end
        repeat (10) step(1'b0, 64'h0);
    endtask

    task automatic test_redirect_wait();
        int guard = 0;
        int n0;
        lat_min = 3; lat_max = 3; req_pct = 100; rdy_pct = 100;
        do_reset();
        while (!(accepts == 3) && guard < 40) begin step(1'b0, 64'h0); guard++; end
        checks++;
        if (last_acc !== 64'h8) begin errors++; $display("FAIL rw_setup_addr: got %h expected 8", last_acc); end
        n0 = accepts;
        step(1'b1, 64'h100);
        wait_accept(n0, "rw");
        checks++;
        if (last_acc !== 64'h100) begin errors++; $display("FAIL rw_next_addr: got %h expected 100", last_acc); end
        repeat (15) step(1'b0, 64'h0);
        checks++;
        if (exp_pop_pc <= 64'h100) begin errors++; $display("FAIL rw_no_delivery: next expected pc %h, nothing from 100 delivered", exp_pop_pc); end
    endtask

    task automatic test_redirect_rsp_pop();
        int guard = 0;
        int n0;
        logic [31:0] held;
        lat_min = 2; lat_max = 2; req_pct = 100; rdy_pct = 0;
        do_reset();
        while (!(mem_pend && mem_dly == 0 && sv_inst_valid) && guard < 40) begin step(1'b0, 64'h0); guard++; end
        rdy_pct = 100;
        step(1'b1, 64'h200);
        held = sv_instr;
        n0 = accepts;
        step(1'b0, 64'h0);
        checks++;
        if (sv_inst_valid !== 1'b0) begin errors++; $display("FAIL rrp_flush: inst_valid=%b expected 0", sv_inst_valid); end
        checks++;
        if (sv_instr !== held) begin errors++; $display("FAIL rrp_hold: instruction=%h expected %h", sv_instr, held); end
        if (accepts == n0) wait_accept(n0, "rrp");
        checks++;
        if (last_acc !== 64'h200) begin errors++; $display("FAIL rrp_next_addr: got %h expected 200", last_acc); end
        repeat (8) step(1'b0, 64'h0);
    endtask

    task automatic test_align_wrap();
        int n0;
        lat_min = 1; lat_max = 1; req_pct = 100; rdy_pct = 100;
        do_reset();
        step(1'b1, 64'h103);
        wait_accept(0, "aw_align");
        checks++;
        if (last_acc !== 64'h100) begin errors++; $display("FAIL aw_align_addr: got %h expected 100", last_acc); end
        n0 = accepts;
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_accept(n0, "aw_top");
        checks++;
        if (last_acc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL aw_top_addr: got %h expected fffffffffffffffc", last_acc); end
        n0 = accepts;
        wait_accept(n0, "aw_wrap");
        checks++;
        if (last_acc !== 64'h0) begin errors++; $display("FAIL aw_wrap_addr: got %h expected 0", last_acc); end
        repeat (6) step(1'b0, 64'h0);
    endtask

    task automatic test_reset_mid_wait();
        int guard = 0;
        lat_min = 3; lat_max = 3; req_pct = 100; rdy_pct = 0;
        do_reset();
        while (accepts < 2 && guard < 40) begin step(1'b0, 64'h0); guard++; end
        step(1'b0, 64'h0);
        #2;
        reset = 1'b0;
        #1;
        checks += 5;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mrst_req_valid: got %b expected 0", imem_req_valid); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL mrst_inst_valid: got %b expected 0", inst_valid); end
        if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL mrst_req_addr: got %h expected 0", imem_req_addr); end
        if (instruction !== 32'h0) begin errors++; $display("FAIL mrst_instruction: got %h expected 0", instruction); end
        if (inst_pc !== 64'h0) begin errors++; $display("FAIL mrst_inst_pc: got %h expected 0", inst_pc); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_clear();
        mem_pend = 1'b1; mem_dly = 0; mem_addr = 64'h8;
        lat_min = 1; lat_max = 1; rdy_pct = 100;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 64'h0);
            checks++;
            if (sv_inst_valid !== 1'b0) begin errors++; $display("FAIL mrst_stale_rsp: inst_valid=%b expected 0 at cycle %0d", sv_inst_valid, i); end
        end
        repeat (10) step(1'b0, 64'h0);
        checks++;
        if (pops < 1) begin errors++; $display("FAIL mrst_resume: got %0d pops expected >= 1", pops); end
    endtask

    task automatic test_random();
        logic [63:0] tgt;
        lat_min = 1; lat_max = 3; req_pct = 70; rdy_pct = 60;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(11) == 0) begin
                if ($urandom_range(3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31));
                else tgt = {$urandom, $urandom};
                step(1'b1, tgt);
            end else begin
                step(1'b0, 64'h0);
            end
        end
        checks++;
        if (pops < 20) begin errors++; $display("FAIL rand_progress: got %0d pops expected >= 20", pops); end
    endtask

    initial begin
        reset = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0; inst_ready = 1'b0;
        lat_min = 1; lat_max = 1; req_pct = 100; rdy_pct = 100;
        last_acc = 64'h0; sv_inst_valid = 1'b0; sv_req_valid = 1'b0; sv_instr = 32'h0;
        model_clear();
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp_pop();
        test_align_wrap();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
